// File: rtl/s_to_u_norm_if.sv
// Stream bundle for the signed-to-unsigned normaliser: input channel (frac_signed with
// valid/ready) and result channel (sign, magnitude, lzc, normalised magnitude, flags).
interface s_to_u_norm_if #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned LZC_W = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] frac_signed;
  logic             out_valid;
  logic             out_ready;
  logic             sign;
  logic [WIDTH-2:0] frac_unsigned;
  logic [LZC_W-1:0] lzc;
  logic [WIDTH-2:0] frac_norm;
  logic             zero;
  logic             ovf;

  // The converter itself.
  modport slave (
    input  in_valid, frac_signed, out_ready,
    output in_ready, out_valid, sign, frac_unsigned, lzc, frac_norm, zero, ovf
  );

  // Producer of fractions and consumer of results.
  modport master (
    output in_valid, frac_signed, out_ready,
    input  in_ready, out_valid, sign, frac_unsigned, lzc, frac_norm, zero, ovf
  );
endinterface

// File: rtl/s_to_u_norm.sv
// Two-stage elastic converter: two's-complement fraction -> sign + saturated magnitude (s1),
// then leading-zero count + left-normalised magnitude (s2). Results come straight from s2.
module s_to_u_norm #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned LZC_W = $clog2(WIDTH)
) (
  input logic          CLK,
  input logic          nRST,
  s_to_u_norm_if.slave bus
);
  localparam int MagW = int'(WIDTH) - 1;

  // Stage 1 state
  logic            r_s1_valid;
  logic            r_s1_sign;
  logic            r_s1_ovf;
  logic [MagW-1:0] r_s1_mag;

  // Stage 2 state (drives the outputs)
  logic             r_s2_valid;
  logic             r_s2_sign;
  logic             r_s2_ovf;
  logic             r_s2_zero;
  logic [MagW-1:0]  r_s2_mag;
  logic [LZC_W-1:0] r_s2_lzc;
  logic [MagW-1:0]  r_s2_norm;

  // Handshake
  logic w_out_fire;
  logic w_s2_can_load;
  logic w_s1_adv;
  logic w_in_ready;
  logic w_in_fire;

  assign w_out_fire    = r_s2_valid && bus.out_ready;
  assign w_s2_can_load = !r_s2_valid || w_out_fire;
  assign w_s1_adv      = r_s1_valid && w_s2_can_load;
  assign w_in_ready    = !r_s1_valid || w_s2_can_load;
  assign w_in_fire     = bus.in_valid && w_in_ready;

  // Stage 1 datapath: the most-negative input has no representable magnitude, so saturate.
  logic            w_neg;
  logic            w_min;
  logic [MagW-1:0] w_neg_mag;
  logic [MagW-1:0] w_mag;

  assign w_neg     = bus.frac_signed[WIDTH-1];
  assign w_min     = w_neg && (bus.frac_signed[MagW-1:0] == '0);
  assign w_neg_mag = -bus.frac_signed[MagW-1:0];
  assign w_mag     = w_min ? '1 : (w_neg ? w_neg_mag : bus.frac_signed[MagW-1:0]);

  // Stage 2 datapath: leading-zero count; a zero magnitude counts as MagW leading zeros.
  logic [LZC_W-1:0] w_lzc;
  logic [MagW-1:0]  w_norm;

  // Scan upward so the highest set bit determines the final count.
  always_comb begin
    w_lzc = LZC_W'(MagW);
    for (int i = 0; i < MagW; i++) begin
      if (r_s1_mag[i]) w_lzc = LZC_W'(MagW - 1 - i);
    end
  end

  assign w_norm = r_s1_mag << w_lzc;

  // Stage valid bits: reset discards anything in flight.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_in_fire || (r_s1_valid && !w_s1_adv);
      r_s2_valid <= w_s1_adv || (r_s2_valid && !w_out_fire);
    end
  end

  // Stage 1 data: capture sign and saturated magnitude on input transfer.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_s1_sign <= 1'b0;
      r_s1_ovf  <= 1'b0;
      r_s1_mag  <= '0;
    end else if (w_in_fire) begin
      r_s1_sign <= w_neg;
      r_s1_ovf  <= w_min;
      r_s1_mag  <= w_mag;
    end
  end

  // Stage 2 data: capture normalisation results when s1 advances; hold otherwise.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_s2_sign <= 1'b0;
      r_s2_ovf  <= 1'b0;
      r_s2_zero <= 1'b0;
      r_s2_mag  <= '0;
      r_s2_lzc  <= '0;
      r_s2_norm <= '0;
    end else if (w_s1_adv) begin
      r_s2_sign <= r_s1_sign;
      r_s2_ovf  <= r_s1_ovf;
      r_s2_zero <= (r_s1_mag == '0);
      r_s2_mag  <= r_s1_mag;
      r_s2_lzc  <= w_lzc;
      r_s2_norm <= w_norm;
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_s2_valid;
  assign bus.sign          = r_s2_sign;
  assign bus.frac_unsigned = r_s2_mag;
  assign bus.lzc           = r_s2_lzc;
  assign bus.frac_norm     = r_s2_norm;
  assign bus.zero          = r_s2_zero;
  assign bus.ovf           = r_s2_ovf;
endmodule

// File: tb/tb_s_to_u_norm.sv
// Scoreboard bench for s_to_u_norm (WIDTH=27): directed vectors with hand-computed results,
// expected entries queued at input transfer, compared by a negedge monitor at output transfer.
module tb_s_to_u_norm;
  localparam int unsigned WIDTH = 27;
  localparam int unsigned LZC_W = 5;

  logic CLK = 1'b0;
  logic nRST;

  s_to_u_norm_if #(.WIDTH(WIDTH), .LZC_W(LZC_W)) bus ();

  s_to_u_norm #(.WIDTH(WIDTH), .LZC_W(LZC_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [26:0] in;
    logic        s;
    logic [25:0] mag;
    logic [4:0]  lzc;
    logic [25:0] norm;
    logic        z;
    logic        o;
    int          cyc;
  } vec_t;

  vec_t vecs[16];
  vec_t q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_acc = 0;
  bit chk_lat = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input logic [26:0] in, input logic s,
                         input logic [25:0] mag, input logic [4:0] lzc,
                         input logic [25:0] norm, input logic z, input logic o);
    vecs[i].in = in;  vecs[i].s = s;      vecs[i].mag = mag;  vecs[i].lzc = lzc;
    vecs[i].norm = norm; vecs[i].z = z;   vecs[i].o = o;      vecs[i].cyc = 0;
  endtask

  // Monitor: pop/compare on output transfer; check outputs hold steady while stalled.
  logic [59:0] hold;
  bit          stall_prev = 1'b0;
  always @(negedge CLK) begin
    if (!nRST) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_data", 64'({bus.sign, bus.frac_unsigned, bus.lzc, bus.frac_norm,
                              bus.zero, bus.ovf}), 64'(hold));
      end
      stall_prev = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 64'(bus.out_valid), 64'd0);
          end else begin
            vec_t e;
            e = q.pop_front();
            chk("sign", 64'(bus.sign), 64'(e.s));
            chk("frac_unsigned", 64'(bus.frac_unsigned), 64'(e.mag));
            chk("lzc", 64'(bus.lzc), 64'(e.lzc));
            chk("frac_norm", 64'(bus.frac_norm), 64'(e.norm));
            chk("zero", 64'(bus.zero), 64'(e.z));
            chk("ovf", 64'(bus.ovf), 64'(e.o));
            if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
          end
        end else begin
          hold = {bus.sign, bus.frac_unsigned, bus.lzc, bus.frac_norm, bus.zero, bus.ovf};
          stall_prev = 1'b1;
        end
      end
    end
  end

  // Offer vecs[first..first+cnt-1] back-to-back, queuing expectations at each transfer.
  task automatic stream(input int first, input int cnt, input int budget);
    int sent = 0;
    int spent = 0;
    while (sent < cnt && spent < budget) begin
      bus.in_valid    = 1'b1;
      bus.frac_signed = vecs[first + sent].in;
      @(negedge CLK);
      if (bus.in_ready) begin
        vec_t e;
        e = vecs[first + sent];
        e.cyc = cyc;
        q.push_back(e);
        sent++;
        n_acc++;
      end
      @(posedge CLK); #1;
      spent++;
    end
    bus.in_valid = 1'b0;
    if (sent < cnt) chk("accept_budget", 64'(sent), 64'(cnt));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("drained", 64'(q.size()), 64'd0);
    @(posedge CLK); #1;
  endtask

  task automatic chk_reset_state();
    @(negedge CLK);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_sign", 64'(bus.sign), 64'd0);
    chk("rst_frac_unsigned", 64'(bus.frac_unsigned), 64'd0);
    chk("rst_lzc", 64'(bus.lzc), 64'd0);
    chk("rst_frac_norm", 64'(bus.frac_norm), 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    //      idx  input          s  mag           lzc  norm          z  o
    set_vec(0,  27'h7FFFFFF, 1, 26'h0000001, 25, 26'h2000000, 0, 0);
    set_vec(1,  27'h4000000, 1, 26'h3FFFFFF, 0,  26'h3FFFFFF, 0, 1);
    set_vec(2,  27'h0000000, 0, 26'h0000000, 26, 26'h0000000, 1, 0);
    set_vec(3,  27'h0000005, 0, 26'h0000005, 23, 26'h2800000, 0, 0);
    set_vec(4,  27'h3FFFFFF, 0, 26'h3FFFFFF, 0,  26'h3FFFFFF, 0, 0);
    set_vec(5,  27'h4000001, 1, 26'h3FFFFFF, 0,  26'h3FFFFFF, 0, 0);
    set_vec(6,  27'h0000001, 0, 26'h0000001, 25, 26'h2000000, 0, 0);
    set_vec(7,  27'h7FFFFF0, 1, 26'h0000010, 21, 26'h2000000, 0, 0);
    set_vec(8,  27'h1234567, 0, 26'h1234567, 1,  26'h2468ACE, 0, 0);
    set_vec(9,  27'h2000000, 0, 26'h2000000, 0,  26'h2000000, 0, 0);
    set_vec(10, 27'h6000000, 1, 26'h2000000, 0,  26'h2000000, 0, 0);
    set_vec(11, 27'h7000000, 1, 26'h1000000, 1,  26'h2000000, 0, 0);
    set_vec(12, 27'h0000100, 0, 26'h0000100, 17, 26'h2000000, 0, 0);
    set_vec(13, 27'h00ABCDE, 0, 26'h00ABCDE, 6,  26'h2AF3780, 0, 0);
    set_vec(14, 27'h7FFFFFE, 1, 26'h0000002, 24, 26'h2000000, 0, 0);
    set_vec(15, 27'h5555555, 1, 26'h2AAAAAB, 0,  26'h2AAAAAB, 0, 0);

    nRST            = 1'b0;
    bus.in_valid    = 1'b0;
    bus.frac_signed = '0;
    bus.out_ready   = 1'b1;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    chk_reset_state();

    // Tests 1-3: single values, unstalled, latency checked.
    chk_lat = 1'b1;
    stream(0, 1, 10); drain(20);
    stream(1, 1, 10); drain(20);
    stream(2, 1, 10); stream(3, 1, 10); drain(20);

    // Test 4: 8 back-to-back; fixed 2-cycle latency on consecutive accepts keeps them dense.
    stream(4, 8, 20); drain(20);
    chk_lat = 1'b0;

    // Test 5: backpressure fills both stages, then release.
    @(posedge CLK); #1 bus.out_ready = 1'b0;
    acc0 = n_acc;
    fork
      stream(12, 4, 40);
      begin
        repeat (6) @(negedge CLK);
        chk("stall_accepts", 64'(n_acc - acc0), 64'd2);
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge CLK); #1 bus.out_ready = 1'b1;
      end
    join
    drain(20);

    // Test 6: reset with both stages full; held results must never appear.
    bus.out_ready = 1'b0;
    stream(0, 2, 10);
    @(negedge CLK);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge CLK); #1;
    nRST = 1'b0;
    q.delete();
    @(posedge CLK); #1;
    nRST = 1'b1;
    bus.out_ready = 1'b1;
    chk_reset_state();
    repeat (4) @(posedge CLK);
    #1;

    // Recovery after reset.
    chk_lat = 1'b1;
    stream(3, 1, 10); drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
